// File: rtl/sram_fifo_pkg.sv
// Shared sizing for the SRAM-backed stream FIFO and its prefetch output queue.
package sram_fifo_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PTR_W     = ptr_width(DEPTH_DEF);
    localparam int CNT_W     = PTR_W + 2;
    // Prefetch queue capacity; the FIFO holds DEPTH + BUF_DEPTH words in total.
    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/sram_fifo_out_buf.sv
// Two-entry in-order output queue fed by SRAM read returns; its head drives m_data.
module sram_fifo_out_buf
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CB    = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic [CB-1:0]    buf_cnt
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop;

    assign m_valid = (buf_cnt != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            buf_cnt <= '0;
        end else begin
            case ({cap, pop})
                2'b10: begin
                    if (buf_cnt == '0) head <= cap_data;
                    else               tail <= cap_data;
                    buf_cnt <= buf_cnt + CB'(1);
                end
                2'b01: begin
                    head    <= tail;
                    buf_cnt <= buf_cnt - CB'(1);
                end
                2'b11: begin
                    // Head leaves while a word arrives: it lands behind whatever remains.
                    if (buf_cnt == CB'(1)) begin
                        head <= cap_data;
                    end else begin
                        head <= tail;
                        tail <= cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Stream FIFO controller for a 1r1w SRAM with one-cycle read latency, hidden by a prefetch queue.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH)+1:0]   count,
    output logic                       mem_wen,
    output logic [WIDTH-1:0]           mem_wdata,
    output logic [$clog2(DEPTH)-1:0]   mem_write_pointer,
    output logic                       mem_ren,
    output logic [$clog2(DEPTH)-1:0]   mem_read_pointer,
    input  logic [WIDTH-1:0]           mem_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam int BW = $clog2(BUF_DEPTH + 1);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   occ;
    logic          inflight;
    logic          push;
    logic          pop;
    logic          issue;
    logic [BW-1:0] buf_cnt;
    logic [BW:0]   pending;

    assign occ     = wr_ptr - rd_ptr;
    assign s_ready = !rst && (occ < DEPTH_V);
    assign push    = s_valid && s_ready;

    assign mem_wen           = push;
    assign mem_wdata         = s_data;
    assign mem_write_pointer = wr_ptr[AW-1:0];

    // Keep queued + in-flight words within the queue's capacity after this cycle's pop.
    assign pop     = m_valid && m_ready;
    assign pending = {1'b0, buf_cnt} + {{BW{1'b0}}, inflight} - {{BW{1'b0}}, pop};
    assign issue   = (occ != '0) && (pending < (BW + 1)'(BUF_DEPTH));

    assign mem_ren          = issue;
    assign mem_read_pointer = rd_ptr[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (issue) rd_ptr <= rd_ptr + (AW + 1)'(1);
            inflight <= issue;
        end
    end

    sram_fifo_out_buf #(
        .WIDTH (WIDTH),
        .CB    (BW)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .cap      (inflight),
        .cap_data (mem_rdata),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .buf_cnt  (buf_cnt)
    );

    assign count = CW'(occ) + CW'(inflight) + CW'(buf_cnt);

    // Invariants the prefetch/push gating relies on.
    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ <= DEPTH_V);
    a_no_buf_overflow: assert property (@(posedge clk) disable iff (rst)
        !(inflight && (buf_cnt == BW'(BUF_DEPTH)) && !pop));
    a_no_rw_collision: assert property (@(posedge clk) disable iff (rst)
        !(mem_wen && mem_ren && (mem_write_pointer == mem_read_pointer)));

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

Synchronous FIFO controller that drives the 1r1w SRAM wrapper (`sky130_sram_1r1w_8x16_8_wrapper`) and presents valid/ready stream interfaces on both sides. It generates write/read pointers and enables for the macro. It hides the one-cycle SRAM read latency behind a 2-entry prefetch output buffer, so the drain side sustains one word per cycle. It sits directly upstream of the SRAM wrapper; the wrapper's ports connect one-to-one to the `mem_*` ports.

## Interface
- `WIDTH`, 8: data word width.
- `DEPTH`, 16: SRAM depth; power of two, ≥2.
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: producer has a word.
- `s_ready` out 1: FIFO accepts a word this cycle.
- `s_data` in WIDTH: producer word.
- `m_valid` out 1: head word available.
- `m_ready` in 1: consumer takes the head word.
- `m_data` out WIDTH: head word.
- `count` out $clog2(DEPTH)+2: total words held (SRAM + in-flight + buffer), 0..DEPTH+2.
- `mem_wen` out 1: SRAM write enable.
- `mem_wdata` out WIDTH: SRAM write data.
- `mem_write_pointer` out $clog2(DEPTH): SRAM write address.
- `mem_ren` out 1: SRAM read enable.
- `mem_read_pointer` out $clog2(DEPTH): SRAM read address.
- `mem_rdata` in WIDTH: SRAM read data.

## Operation
- **Pointers.**
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - SRAM occupancy `occ = wr_ptr − rd_ptr`, computed modulo 2^(PTR_W+1).
  - Addresses are the low PTR_W bits; they wrap DEPTH−1 → 0.
- **Push.**
  - `s_ready = !rst && (occ < DEPTH)`, derived from registers only.
  - On `s_valid && s_ready`: `mem_wen=1`, `mem_wdata=s_data`, `mem_write_pointer=wr_ptr[PTR_W-1:0]`, and `wr_ptr` increments.
  - `mem_wen` is combinational from `s_valid`.
- **Pop.**
  - `pop = m_valid && m_ready` removes the buffer head.
  - `m_data` = buffer head register.
- **Prefetch.**
  - Let `pop` be as above and `issue = (occ > 0) && (buf_cnt + inflight − pop < 2)`.
  - On `issue`: `mem_ren=1`, `mem_read_pointer=rd_ptr[PTR_W-1:0]`, `rd_ptr` increments, and `inflight` is set for the next cycle.
  - When `inflight=1`, `mem_rdata` is written into the buffer tail at the end of that cycle.
- **Output buffer.**
  - 2-entry in-order queue: head/tail registers and `buf_cnt` (0..2).
  - `m_valid = (buf_cnt != 0)`.
  - Simultaneous capture and pop: the head advances and the new word goes to the correct slot. Order is preserved and no word is lost or duplicated.
- **Read/write collision.** Reads are issued only against `occ` computed from registered pointers. A word written at edge N is first readable in cycle N+1, so the same address is never read and written in one cycle and no bypass is needed.
- **Count.** `count = occ + inflight + buf_cnt`, registered-source combinational.

## Timing
- **Reset values** (`rst` high, async):
  - `wr_ptr=rd_ptr=0`, `inflight=0`, `buf_cnt=0`, buffer data 0.
  - Outputs: `m_valid=0`, `m_data=0`, `count=0`, `s_ready=0`, `mem_wen=0`, `mem_ren=0`, both pointers 0.
- **After reset release.** `s_ready=1` from the first cycle after `rst` falls.
- **Latency.**
  - Word accepted in cycle 0.
  - `mem_ren` for it in cycle 1.
  - `mem_rdata` captured at the end of cycle 2.
  - `m_valid` high in cycle 3.
- **Throughput.** With `m_ready` held high and a continuous producer, one word per cycle after the initial latency, with no bubbles.
- **Full.**
  - Capacity is DEPTH+2 (18 by default).
  - `s_ready` falls when `occ == DEPTH`.
  - `s_ready` rises the cycle after a prefetch issue frees a slot.
- **Empty.** `m_valid=0` when `buf_cnt==0`, including while a read is in flight.
- **Reset mid-operation.** All contents and any in-flight read are discarded, and `mem_rdata` is ignored. The first word pushed after reset is the first popped.

## Structure
- Package `sram_fifo_pkg`:
  - `PTR_W=$clog2(DEPTH)`
  - `CNT_W=$clog2(DEPTH)+2`
  - the capacity constant `BUF_DEPTH=2`
- Sub-module `sram_fifo_out_buf`:
  - the 2-entry output queue
  - inputs: capture strobe + data, `m_ready`
  - outputs: `m_valid`, `m_data`, `buf_cnt`
- The top holds the pointers, the prefetch issue logic, `inflight`, and `count`.

## Test plan
- **Single word.** Reset, push 0xA5 in one cycle → `mem_wen` with address 0 in cycle 0, `mem_ren` with address 0 in cycle 1, `m_valid=1` with `m_data=0xA5` in cycle 3, `count=1` from cycle 1.
- **Fill.** `m_ready=0`, `s_valid=1` pushing 0x00..0x13 → exactly 18 accepted (0x00..0x11), `s_ready=0` thereafter, `count=18`. Then `m_ready=1` drains 0x00..0x11 in order and `count` reaches 0.
- **Streaming.** `s_valid=m_ready=1` for 100 sequential words → after cycle 3, `m_valid` stays high every cycle, data is in order, and `count` is ≤3 throughout.
- **Wrap with backpressure.** 50 words with random `m_ready` (50%) → both pointers wrap 15→0 at least twice, output order is exact, and the scoreboard shows no loss or duplication.
- **Full plus pop.** From full, one cycle of `m_ready=1` with `s_valid=1` → exactly one pop. `s_ready` returns to 1 within 2 cycles, the next push is accepted, and `count` returns to 18.
- **Mid-operation reset.** Assert `rst` while `inflight=1` and `count=5` → all outputs at reset values immediately. After release, push 0x3C → `m_data=0x3C` is the first output.
